// File: rtl/id_ex_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared pipeline definitions for the ID/EX stage register.
//   CTRL_W          width of the Controller control bundle
//   CTRL_*          bit positions inside the bundle
//                   {MemtoReg,MemWrite,Branch[1:0],ALUOP[2:0],ALUSrc,RegDst,RegWrite,SgnZero}
//   CTRL_BUBBLE     all-zero bundle: RegWrite=0, MemWrite=0, Branch=00, i.e. a NOP
//   aluop_e         ALUOP field encodings
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int CTRL_W         = 11;
  localparam int CTRL_MEMTOREG  = 10;
  localparam int CTRL_MEMWRITE  = 9;
  localparam int CTRL_BRANCH_HI = 8;
  localparam int CTRL_BRANCH_LO = 7;
  localparam int CTRL_ALUOP_HI  = 6;
  localparam int CTRL_ALUOP_LO  = 4;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_REGDST    = 2;
  localparam int CTRL_REGWRITE  = 1;
  localparam int CTRL_SGNZERO   = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 11'b000_0000_0000;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_LUI   = 3'b110,
    ALUOP_XOR   = 3'b111
  } aluop_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if : ID-side inputs and EX-side outputs of the ID/EX register.
//   master : decode side / testbench (drives id_*, observes ex_*)
//   slave  : the stage register (consumes id_*, drives ex_*)
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) ();

  logic                  id_valid;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [DATA_W-1:0]     id_pc4;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [15:0]           id_imm16;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;

  logic                  ex_valid;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [DATA_W-1:0]     ex_pc4;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;

  modport master (
    output id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm16, id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard detector.
//   A load sitting in EX whose destination (rt) is read by the instruction in
//   ID cannot be forwarded in time; register $0 never creates a dependency.
//   ex_valid, ex_memtoreg, ex_rt : state of the EX slot
//   id_valid, id_rs, id_rt       : instruction currently in ID
//   hazard                       : ID must wait one cycle
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_memtoreg,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard
);

  logic rt_nonzero_s;
  logic rt_match_s;

  assign rt_nonzero_s = (ex_rt != {REG_ADDR_W{1'b0}});
  assign rt_match_s   = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign hazard       = ex_valid & ex_memtoreg & rt_nonzero_s & rt_match_s & id_valid;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg : ID/EX pipeline register.
//   Latches the Controller bundle, operands and specifiers each cycle, forms the
//   extended immediate (SgnZero=1 zero-extends, else sign-extends), and loads a
//   bubble (everything zero) on flush, load-use hazard or invalid decode, in that
//   priority. stall_o freezes PC and IF/ID while a load-use bubble is inserted;
//   a flush in the same cycle wins and suppresses the stall.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        branch taken in EX, kill the ID instruction
//   stall_o      load-use hazard (combinational)
//   bus          id_ex_stage_reg_if.slave : id_* in, ex_* out (registered)
//   bubble_cnt, flush_cnt  saturating perf counters (ID_EX_PERF_CNT_EN only)
// Configuration macro: ID_EX_PERF_CNT_EN
// ---------------------------------------------------------------------------
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             stall_o,
  id_ex_stage_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic                  hazard_s;
  logic                  bubble_s;
  logic [DATA_W-1:0]     imm_ext_s;

  logic                  valid_s,   valid_r;
  logic [CTRL_W-1:0]     ctrl_s,    ctrl_r;
  logic [DATA_W-1:0]     pc4_s,     pc4_r;
  logic [DATA_W-1:0]     rs_data_s, rs_data_r;
  logic [DATA_W-1:0]     rt_data_s, rt_data_r;
  logic [DATA_W-1:0]     imm_s,     imm_r;
  logic [REG_ADDR_W-1:0] rs_s,      rs_r;
  logic [REG_ADDR_W-1:0] rt_s,      rt_r;
  logic [REG_ADDR_W-1:0] rd_s,      rd_r;

  // Hazard looks at the registered EX slot, so an async reset clears it at once.
  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .ex_valid    (valid_r),
    .ex_memtoreg (ctrl_r[CTRL_MEMTOREG]),
    .ex_rt       (rt_r),
    .id_valid    (bus.id_valid),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .hazard      (hazard_s)
  );

  assign stall_o  = hazard_s & ~flush;
  assign bubble_s = flush | hazard_s | ~bus.id_valid;

  // Immediate extension ahead of the register.
  always_comb begin
    if (bus.id_ctrl[CTRL_SGNZERO]) begin
      imm_ext_s = {{(DATA_W-16){1'b0}}, bus.id_imm16};
    end else begin
      imm_ext_s = {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16};
    end
  end

  // Bubble mux: a bubble zeroes every field so EX sees an architectural NOP.
  always_comb begin
    valid_s   = 1'b0;
    ctrl_s    = CTRL_BUBBLE;
    pc4_s     = {DATA_W{1'b0}};
    rs_data_s = {DATA_W{1'b0}};
    rt_data_s = {DATA_W{1'b0}};
    imm_s     = {DATA_W{1'b0}};
    rs_s      = {REG_ADDR_W{1'b0}};
    rt_s      = {REG_ADDR_W{1'b0}};
    rd_s      = {REG_ADDR_W{1'b0}};
    if (bubble_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s   = 1'b1;
      ctrl_s    = bus.id_ctrl;
      pc4_s     = bus.id_pc4;
      rs_data_s = bus.id_rs_data;
      rt_data_s = bus.id_rt_data;
      imm_s     = imm_ext_s;
      rs_s      = bus.id_rs;
      rt_s      = bus.id_rt;
      rd_s      = bus.id_rd;
    end
  end

  // ID/EX register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      ctrl_r    <= CTRL_BUBBLE;
      pc4_r     <= {DATA_W{1'b0}};
      rs_data_r <= {DATA_W{1'b0}};
      rt_data_r <= {DATA_W{1'b0}};
      imm_r     <= {DATA_W{1'b0}};
      rs_r      <= {REG_ADDR_W{1'b0}};
      rt_r      <= {REG_ADDR_W{1'b0}};
      rd_r      <= {REG_ADDR_W{1'b0}};
    end else begin
      valid_r   <= valid_s;
      ctrl_r    <= ctrl_s;
      pc4_r     <= pc4_s;
      rs_data_r <= rs_data_s;
      rt_data_r <= rt_data_s;
      imm_r     <= imm_s;
      rs_r      <= rs_s;
      rt_r      <= rt_s;
      rd_r      <= rd_s;
    end
  end

  assign bus.ex_valid   = valid_r;
  assign bus.ex_ctrl    = ctrl_r;
  assign bus.ex_pc4     = pc4_r;
  assign bus.ex_rs_data = rs_data_r;
  assign bus.ex_rt_data = rt_data_r;
  assign bus.ex_imm     = imm_r;
  assign bus.ex_rs      = rs_r;
  assign bus.ex_rt      = rt_r;
  assign bus.ex_rd      = rd_r;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Bubble counter: any bubble load, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (bubble_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  // Flush counter: every cycle with flush high, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
      flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg : self-checking bench for id_ex_stage_reg.
//   Directed scenarios plus a randomized run, all checked against a
//   behavioural model of the EX slot (and of the perf counters when
//   ID_EX_PERF_CNT_EN is defined).
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;
  localparam int VW = 1 + CTRL_W + 4*DW + 3*RW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic stall_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  id_ex_stage_reg #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .stall_o (stall_o),
    .bus     (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // Reference model of the EX slot.
  typedef struct {
    logic          valid;
    logic [10:0]   ctrl;
    logic [DW-1:0] pc4, rs_data, rt_data, imm;
    logic [RW-1:0] rs, rt, rd;
  } ex_t;

  ex_t m;
  int  m_bub = 0;
  int  m_fl  = 0;

  localparam logic [10:0] C_ADDI = 11'b0_0_00_000_1_0_1_0;
  localparam logic [10:0] C_ORI  = 11'b0_0_00_100_1_0_1_1;
  localparam logic [10:0] C_LW   = 11'b1_0_00_000_1_0_1_0;
  localparam logic [10:0] C_ADD  = 11'b0_0_00_010_0_1_1_0;

  function automatic ex_t empty_slot();
    ex_t e;
    e.valid = 1'b0; e.ctrl = 11'd0;
    e.pc4 = 32'd0; e.rs_data = 32'd0; e.rt_data = 32'd0; e.imm = 32'd0;
    e.rs = 5'd0; e.rt = 5'd0; e.rd = 5'd0;
    return e;
  endfunction

  // A load in EX whose target is read by the ID instruction (never $0).
  function automatic bit model_hazard();
    return m.valid && m.ctrl[10] && (m.rt != 5'd0) &&
           ((m.rt == bus.id_rs) || (m.rt == bus.id_rt)) && bus.id_valid;
  endfunction

  function automatic logic [DW-1:0] extend(input logic [15:0] v, input logic zero_ext);
    int unsigned u;
    u = v;
    if (zero_ext)        return DW'(u);
    else if (u >= 32768) return DW'(u) - 32'd65536;
    else                 return DW'(u);
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.ex_valid, bus.ex_ctrl, bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data,
            bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m.valid, m.ctrl, m.pc4, m.rs_data, m.rt_data, m.imm, m.rs, m.rt, m.rd};
  endfunction

  task automatic set_id(input logic v, input logic [10:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    bus.id_valid   = v;
    bus.id_ctrl    = c;
    bus.id_pc4     = $urandom;
    bus.id_rs_data = $urandom;
    bus.id_rt_data = $urandom;
    bus.id_imm16   = imm;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
  endtask

  // Advance one clock: the model takes the same decision the stage must take.
  task automatic clk_edge();
    ex_t nxt;
    bit  bub;
    bub = flush || model_hazard() || !bus.id_valid;
    if (bub) begin
      nxt = empty_slot();
    end else begin
      nxt.valid   = 1'b1;
      nxt.ctrl    = bus.id_ctrl;
      nxt.pc4     = bus.id_pc4;
      nxt.rs_data = bus.id_rs_data;
      nxt.rt_data = bus.id_rt_data;
      nxt.imm     = extend(bus.id_imm16, bus.id_ctrl[0]);
      nxt.rs      = bus.id_rs;
      nxt.rt      = bus.id_rt;
      nxt.rd      = bus.id_rd;
    end
    @(posedge clk);
    m = nxt;
    if (bub   && m_bub < 65535) m_bub++;
    if (flush && m_fl  < 65535) m_fl++;
    #1;
  endtask

  task automatic test_reset();
    set_id(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    m = empty_slot();
    #2;
    checks++;
    if (act_vec() !== {VW{1'b0}}) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", act_vec());
    end
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b want=0", stall_o);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", bubble_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    clk_edge();
  endtask

  task automatic test_sign_ext();
    set_id(1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 16'hFFFC);
    clk_edge();
    checks++;
    if (bus.ex_imm !== 32'hFFFF_FFFC || bus.ex_valid !== 1'b1) begin
      failures++; $display("FAIL addi_imm got=%h v=%b want=fffffffc v=1", bus.ex_imm, bus.ex_valid);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL addi_slot got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_zero_ext();
    set_id(1'b1, C_ORI, 5'd3, 5'd4, 5'd0, 16'h8001);
    clk_edge();
    checks++;
    if (bus.ex_imm !== 32'h0000_8001 || bus.ex_ctrl !== C_ORI) begin
      failures++; $display("FAIL ori_imm got=%h ctrl=%b want=00008001", bus.ex_imm, bus.ex_ctrl);
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, C_LW, 5'd3, 5'd5, 5'd0, 16'h0010);
    clk_edge();
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 16'h3820);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b want=1", stall_o);
    end
    clk_edge();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 11'd0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL lu_bubble got v=%b ctrl=%b stall=%b want 0/0/0",
                           bus.ex_valid, bus.ex_ctrl, stall_o);
    end
    clk_edge();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== C_ADD || bus.ex_rs !== 5'd5 || bus.ex_rd !== 5'd7) begin
      failures++; $display("FAIL lu_release got v=%b ctrl=%b rs=%0d rd=%0d want 1/%b/5/7",
                           bus.ex_valid, bus.ex_ctrl, bus.ex_rs, bus.ex_rd, C_ADD);
    end
  endtask

  task automatic test_zero_reg_exempt();
    set_id(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 16'h0004);
    clk_edge();
    set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 16'h4820);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL r0_stall got=%b want=0", stall_o);
    end
    clk_edge();
    checks++;
    if (bus.ex_valid !== 1'b1 || act_vec() !== exp_vec()) begin
      failures++; $display("FAIL r0_load got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_stall();
    set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 16'h0008);
    clk_edge();
    set_id(1'b1, C_ADD, 5'd5, 5'd5, 5'd8, 16'h4020);
    flush = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL fs_stall got=%b want=0", stall_o);
    end
    clk_edge();
    flush = 1'b0;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 11'd0) begin
      failures++; $display("FAIL fs_bubble got v=%b ctrl=%b want 0/0", bus.ex_valid, bus.ex_ctrl);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== CW'(m_bub) || flush_cnt !== CW'(m_fl)) begin
      failures++; $display("FAIL fs_cnt got=%0d/%0d want=%0d/%0d", bubble_cnt, flush_cnt, m_bub, m_fl);
    end
`endif
    // The stalled instruction is re-presented without flush and now loads.
    clk_edge();
    checks++;
    if (act_vec() !== exp_vec() || bus.ex_valid !== 1'b1) begin
      failures++; $display("FAIL fs_after got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [10:0] c;
    for (int i = 0; i < 400; i++) begin
      c = 11'($urandom);
      c[10] = ($urandom_range(0, 99) < 40);
      set_id(($urandom_range(0, 99) < 85), c, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), 16'($urandom));
      flush = ($urandom_range(0, 99) < 10);
      #1;
      checks++;
      if (stall_o !== (model_hazard() && !flush)) begin
        failures++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, stall_o, model_hazard() && !flush);
      end
      clk_edge();
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL rnd_slot i=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    flush = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== CW'(m_bub) || flush_cnt !== CW'(m_fl)) begin
      failures++; $display("FAIL rnd_cnt got=%0d/%0d want=%0d/%0d", bubble_cnt, flush_cnt, m_bub, m_fl);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, C_LW, 5'd1, 5'd6, 5'd0, 16'h0000);
    clk_edge();
    set_id(1'b1, C_ADD, 5'd2, 5'd6, 5'd3, 16'h1820);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++; $display("FAIL rms_pre got=%b want=1", stall_o);
    end
    rst_n = 1'b0;
    m     = empty_slot();
    m_bub = 0;
    m_fl  = 0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || act_vec() !== {VW{1'b0}}) begin
      failures++; $display("FAIL rms_reset got stall=%b slot=%h want 0/0", stall_o, act_vec());
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL rms_cnt got=%0d/%0d want=0/0", bubble_cnt, flush_cnt);
    end
`endif
    #1;
    rst_n = 1'b1;
    clk_edge();
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++; $display("FAIL rms_after got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_zero_ext();
    test_load_use();
    test_zero_reg_exempt();
    test_flush_stall();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
